// File: rtl/bf_pkg.sv
// Shared opcodes, FSM states and error codes for the Brainfuck execution core.
package bf_pkg;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_INC_DP = 4'd1;
   localparam logic [3:0] OP_DEC_DP = 4'd2;
   localparam logic [3:0] OP_INC    = 4'd3;
   localparam logic [3:0] OP_DEC    = 4'd4;
   localparam logic [3:0] OP_OUT    = 4'd5;
   localparam logic [3:0] OP_IN     = 4'd6;
   localparam logic [3:0] OP_OPEN   = 4'd7;
   localparam logic [3:0] OP_CLOSE  = 4'd8;
   localparam logic [3:0] OP_HALT   = 4'd15;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_SKIP_F,
      S_SKIP_E,
      S_OUT_WAIT,
      S_IN_WAIT,
      S_HALT,
      S_ERROR
   } state_t;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] STK_OVF   = 3'd1;
   localparam logic [2:0] STK_UNF   = 3'd2;
   localparam logic [2:0] UNMATCHED = 3'd3;
   localparam logic [2:0] PTR_OOB   = 3'd4;

endpackage

// File: rtl/bf_loop_stack.sv
// Return-address LIFO for loop starts; holds the pc of each open '['.
module bf_loop_stack
   import bf_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_clr,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_top,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;

   logic [W-1:0]    r_mem [DEPTH];
   logic [SP_W-1:0] r_sp;
   logic [SP_W-1:0] w_sp_dec;

   assign w_sp_dec = r_sp - SP_W'(1);
   assign o_top    = r_mem[w_sp_dec[IDX_W-1:0]];
   assign o_full   = (r_sp == SP_W'(DEPTH));
   assign o_empty  = (r_sp == '0);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_sp <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (i_clr) begin
         r_sp <= '0;
      end else if (i_push) begin
         r_mem[r_sp[IDX_W-1:0]] <= i_data;
         r_sp <= r_sp + SP_W'(1);
      end else if (i_pop) begin
         r_sp <= r_sp - SP_W'(1);
      end
   end

endmodule

// File: rtl/bf_core_param.sv
// Parametrised Brainfuck core: external program ROM, internal tape, hardware loop stack.
// Optional pointer bounds checking is enabled by defining BF_PTR_BOUNDS_EN.
module bf_core_param
   import bf_pkg::*;
#(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned DP_W        = 8,
   parameter int unsigned CELL_W      = 8,
   parameter int unsigned STACK_DEPTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   output logic [PC_W-1:0]   pm_addr,
   input  logic [3:0]        pm_data,
   input  logic              in_valid,
   input  logic [CELL_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CELL_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              halted,
   output logic              error,
   output logic [2:0]        err_code
);

   localparam int unsigned TAPE_N  = 2**DP_W;
   localparam int unsigned DEPTH_W = PC_W + 1;

   state_t              r_state;
   logic [PC_W-1:0]     r_pc;
   logic [DP_W-1:0]     r_dp;
   logic [DEPTH_W-1:0]  r_depth;
   logic [CELL_W-1:0]   r_tape [TAPE_N];
   logic                r_out_valid;
   logic [CELL_W-1:0]   r_out_data;
   logic                r_in_ready;
   logic                r_busy;
   logic                r_halted;
   logic                r_error;
   logic [2:0]          r_err_code;

   logic [CELL_W-1:0]   w_cell;
   logic                w_cell_nz;
   logic [PC_W-1:0]     w_pc_inc;
   logic                w_pc_last;
   logic                w_go;
   logic                w_push;
   logic                w_pop;
   logic [PC_W-1:0]     w_top;
   logic                w_full;
   logic                w_empty;
   logic                w_fault;
   logic [2:0]          w_fault_code;

   assign w_cell    = r_tape[r_dp];
   assign w_cell_nz = (w_cell != '0);
   assign w_pc_inc  = r_pc + PC_W'(1);
   assign w_pc_last = (r_pc == '1);
   assign w_go      = go && (r_state == S_IDLE || r_state == S_HALT || r_state == S_ERROR);
   assign w_push    = (r_state == S_EXEC) && (pm_data == OP_OPEN) && w_cell_nz && !w_full;
   assign w_pop     = (r_state == S_EXEC) && (pm_data == OP_CLOSE) && !w_cell_nz && !w_empty;

   bf_loop_stack #(
      .W     (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .i_clock (clock),
      .i_reset (reset),
      .i_clr   (w_go),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_pc),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Fault detection for the current decode; takes priority over normal execution.
   always_comb begin
      w_fault      = 1'b0;
      w_fault_code = ERR_NONE;
      if (r_state == S_EXEC) begin
         case (pm_data)
            OP_OPEN: begin
               if (w_cell_nz && w_full) begin
                  w_fault      = 1'b1;
                  w_fault_code = STK_OVF;
               end else if (!w_cell_nz && w_pc_last) begin
                  w_fault      = 1'b1;
                  w_fault_code = UNMATCHED;
               end
            end
            OP_CLOSE: begin
               if (w_empty) begin
                  w_fault      = 1'b1;
                  w_fault_code = STK_UNF;
               end
            end
`ifdef BF_PTR_BOUNDS_EN
            OP_INC_DP: begin
               if (r_dp == '1) begin
                  w_fault      = 1'b1;
                  w_fault_code = PTR_OOB;
               end
            end
            OP_DEC_DP: begin
               if (r_dp == '0) begin
                  w_fault      = 1'b1;
                  w_fault_code = PTR_OOB;
               end
            end
`endif
            default: ;
         endcase
      end else if (r_state == S_SKIP_E && w_pc_last &&
                   !(pm_data == OP_CLOSE && r_depth == DEPTH_W'(1))) begin
         w_fault      = 1'b1;
         w_fault_code = UNMATCHED;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_dp        <= '0;
         r_depth     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= ERR_NONE;
         for (int i = 0; i < int'(TAPE_N); i++) r_tape[i] <= '0;
      end else if (w_fault) begin
         r_state    <= S_ERROR;
         r_busy     <= 1'b0;
         r_error    <= 1'b1;
         r_err_code <= w_fault_code;
      end else begin
         case (r_state)
            S_IDLE, S_HALT, S_ERROR: begin
               if (go) begin
                  r_state    <= S_FETCH;
                  r_pc       <= '0;
                  r_dp       <= '0;
                  r_depth    <= '0;
                  r_busy     <= 1'b1;
                  r_halted   <= 1'b0;
                  r_error    <= 1'b0;
                  r_err_code <= ERR_NONE;
               end
            end
            S_FETCH: r_state <= S_EXEC;
            S_EXEC: begin
               r_pc    <= w_pc_inc;
               r_state <= S_FETCH;
               case (pm_data)
                  OP_INC_DP: r_dp <= r_dp + DP_W'(1);
                  OP_DEC_DP: r_dp <= r_dp - DP_W'(1);
                  OP_INC:    r_tape[r_dp] <= w_cell + CELL_W'(1);
                  OP_DEC:    r_tape[r_dp] <= w_cell - CELL_W'(1);
                  OP_OUT: begin
                     r_pc        <= r_pc;
                     r_out_data  <= w_cell;
                     r_out_valid <= 1'b1;
                     r_state     <= S_OUT_WAIT;
                  end
                  OP_IN: begin
                     r_pc       <= r_pc;
                     r_in_ready <= 1'b1;
                     r_state    <= S_IN_WAIT;
                  end
                  OP_OPEN: begin
                     if (!w_cell_nz) begin
                        r_depth <= DEPTH_W'(1);
                        r_state <= S_SKIP_F;
                     end
                  end
                  // Taken backward branch re-enters just past the matching '['.
                  OP_CLOSE: if (w_cell_nz) r_pc <= w_top + PC_W'(1);
                  OP_HALT: begin
                     r_pc     <= r_pc;
                     r_state  <= S_HALT;
                     r_busy   <= 1'b0;
                     r_halted <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_SKIP_F: r_state <= S_SKIP_E;
            S_SKIP_E: begin
               r_pc    <= w_pc_inc;
               r_state <= S_SKIP_F;
               if (pm_data == OP_OPEN) begin
                  r_depth <= r_depth + DEPTH_W'(1);
               end else if (pm_data == OP_CLOSE) begin
                  r_depth <= r_depth - DEPTH_W'(1);
                  if (r_depth == DEPTH_W'(1)) r_state <= S_FETCH;
               end
            end
            S_OUT_WAIT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_pc        <= w_pc_inc;
                  r_state     <= S_FETCH;
               end
            end
            S_IN_WAIT: begin
               if (in_valid) begin
                  r_tape[r_dp] <= in_data;
                  r_in_ready   <= 1'b0;
                  r_pc         <= w_pc_inc;
                  r_state      <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pm_addr   = r_pc;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
   assign halted    = r_halted;
   assign error     = r_error;
   assign err_code  = r_err_code;

endmodule
